vga_display_ctrl: RTL and testbench
===================================

Name: vga_display_ctrl

Overview:
Display-side consumer of the frame buffer. Runs on the display pixel clock and generates 640x480@60 VGA timing. Issues sequential frame-buffer read addresses, and for each visible pixel converts the returned 12-bit RGB444 word into aligned RGB, hsync, vsync and data-enable outputs. It drives the frame buffer's read address and receives its read data.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
RD_LATENCY, 1, clocks from o_raddr change to valid i_rdata (registered BRAM read)

Ports:
i_clk  in  1  pixel clock (25.175 MHz nominal); the block's only clock
i_rstn  in  1  asynchronous active-low reset
i_en  in  1  display enable; low holds timing at origin and blanks outputs
o_raddr  out  19  frame-buffer read address, 0..307199
i_rdata  in  12  frame-buffer read data {R[11:8],G[7:4],B[3:0]}
o_red  out  4  pixel red
o_green  out  4  pixel green
o_blue  out  4  pixel blue
o_hsync  out  1  horizontal sync, active low
o_vsync  out  1  vertical sync, active low
o_de  out  1  data enable, high during visible pixels
o_frame_start  out  1  one-clock pulse aligned with the first visible pixel (0,0) of each frame

Behaviour:
- Reset (async assert, sync release): hcnt=0, vcnt=0, addr_cnt=0. Outputs: o_raddr=0, o_rgb=0, o_hsync=1, o_vsync=1, o_de=0, o_frame_start=0. The delay pipeline clears to the same values.
- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL=800); vcnt 0..V_TOTAL-1 (V_TOTAL=525). vcnt advances when hcnt wraps. Both wrap to 0 after (799,524).
- Counter region order: active, front porch, sync, back porch. Active region: hcnt<640 and vcnt<480.
- Raw sync timing: hsync low for hcnt in [656,751]; vsync low for vcnt in [490,491].
- Address generation (no multiplier):
  - addr_cnt increments on each active counter position.
  - addr_cnt resets to 0 when (hcnt,vcnt)=(799,524).
  - o_raddr is registered. On an active cycle it takes addr_cnt; otherwise it holds its value.
  - o_raddr never exceeds 307199.
- Pipeline: total latency L = 2+RD_LATENCY clocks (default 3).
  - Counter state at cycle n drives o_raddr at n+1.
  - i_rdata is valid at n+1+RD_LATENCY.
  - o_red/o_green/o_blue/o_de/o_hsync/o_vsync/o_frame_start are registered at n+L.
  - sync/de/frame_start are delayed through an L-1 deep shift register so all outputs stay mutually aligned.
- Blanking: whenever delayed de=0, RGB outputs are 0, regardless of i_rdata.
- i_en low:
  - Counters and addr_cnt are forced to 0 on the next clock.
  - The pipeline input is driven to the blank/inactive-sync state, so after L clocks all outputs are at their reset values.
  - o_raddr holds.
- i_en rising: timing starts at (0,0), and the first visible pixel appears L clocks later with o_frame_start=1. i_en toggling mid-frame aborts that frame; there is no partial-frame resume.
- Reset mid-frame: all state returns to reset values immediately; restart follows the i_en rules.
- Frame-buffer interface: read-only. The block assumes data at an address is stable once written; it does not coordinate with writes.

Decomposition:
- Package vga_pkg holds:
  - the timing localparams and derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END;
  - FB_DEPTH=307200 and FB_AW=19;
  - a packed struct rgb444_t {r,g,b}.
- Sub-module vga_timing contains hcnt/vcnt, the raw active/hsync/vsync/frame_start flags and the i_en gating. The top level adds address generation, the delay pipeline and the output registers.

Test Plan:
- Reset, then i_en=1 for 2 frames: hsync low exactly 96 clocks every 800 clocks; vsync low exactly 1600 clocks (2 lines) every 420000 clocks; o_de high 640 clocks per line on 480 lines.
- Address sequence over a full frame: o_raddr steps 0,1,2,...,307199 with no skips or repeats, then returns to 0 on the first active cycle of the next frame; bounds assertion o_raddr<307200 holds throughout.
- Data alignment: bench BRAM model returns i_rdata = addr[11:0] after RD_LATENCY. At each clock with o_de=1, {o_red,o_green,o_blue} equals the 12 LSBs of the address issued L-1 clocks earlier. Repeat with RD_LATENCY=2.
- First pixel: pixel (0,0) preloaded with 0xF0A. o_frame_start=1 and RGB=F,0,A exactly L clocks after i_en rises. o_frame_start pulses once per frame.
- Blanking: i_rdata forced to 0xFFF constantly. RGB is 0 on every clock where o_de=0, including porches and vsync lines.
- i_en dropped at pixel (320,200), raised 50 clocks later: outputs at reset values within L clocks of the drop. The next frame starts at o_raddr=0 with o_frame_start, with no sync glitch shorter than spec.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, frame-buffer geometry and pixel types for the
// VGA display controller.
package vga_pkg;

    // 640x480@60 timing, all values in pixel clocks or lines
    localparam int unsigned H_ACTIVE     = 32'd640;
    localparam int unsigned H_FP         = 32'd16;
    localparam int unsigned H_SYNC       = 32'd96;
    localparam int unsigned H_BP         = 32'd48;
    localparam int unsigned V_ACTIVE     = 32'd480;
    localparam int unsigned V_FP         = 32'd10;
    localparam int unsigned V_SYNC       = 32'd2;
    localparam int unsigned V_BP         = 32'd33;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 32'd1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 32'd1;

    // Frame buffer: one RGB444 word per visible pixel
    localparam int unsigned FB_DEPTH     = 32'd307200;
    localparam int unsigned FB_AW        = 32'd19;
    localparam int unsigned RD_LATENCY   = 32'd1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // Frame-buffer words are stored as {R,G,B} nibbles
    function automatic rgb444_t to_rgb(input logic [11:0] word);
        return rgb444_t'(word);
    endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// Frame-buffer read port: the controller drives the address, the memory
// returns the RGB444 word a fixed number of clocks later.
interface vga_fb_if;
    import vga_pkg::*;

    logic [FB_AW-1:0] raddr;
    logic [11:0]      rdata;

    modport master (output raddr, input rdata);
    modport slave  (input raddr, output rdata);
endinterface

// File: rtl/vga_display_ctrl_timing.sv
// Horizontal/vertical raster counters and the raw (undelayed) region flags.
// Display enable low parks the raster at the origin and reports blanking.
module vga_timing #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    output logic o_active,
    output logic o_hsync_n,
    output logic o_vsync_n,
    output logic o_frame_start,
    output logic o_frame_end
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC - 32'd1;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC - 32'd1;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_last_s, v_last_s;

    assign h_last_s = (hcnt_q == HW'(H_TOTAL - 32'd1));
    assign v_last_s = (vcnt_q == VW'(V_TOTAL - 32'd1));

    // Raster advance: pixel counter every clock, line counter on pixel wrap
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!i_en) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (h_last_s) begin
            hcnt_d = '0;
            vcnt_d = v_last_s ? '0 : (vcnt_q + VW'(1));
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end
    end

    // Raster counter registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Region decode; disabled display looks like blanking with syncs released
    always_comb begin
        o_active      = 1'b0;
        o_hsync_n     = 1'b1;
        o_vsync_n     = 1'b1;
        o_frame_start = 1'b0;
        o_frame_end   = 1'b0;
        if (i_en) begin
            o_active      = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
            o_hsync_n     = !((hcnt_q >= HW'(HS_BEG)) && (hcnt_q <= HW'(HS_END)));
            o_vsync_n     = !((vcnt_q >= VW'(VS_BEG)) && (vcnt_q <= VW'(VS_END)));
            o_frame_start = (hcnt_q == '0) && (vcnt_q == '0);
            o_frame_end   = h_last_s && v_last_s;
        end else begin
            o_active      = 1'b0;
            o_frame_end   = 1'b0;
        end
    end
endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display controller: raster timing, sequential frame-buffer reads and
// a delay line that keeps sync/enable aligned with the returned pixel data.
module vga_display_ctrl import vga_pkg::*; #(
    parameter int unsigned RD_LATENCY = vga_pkg::RD_LATENCY,
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP       = vga_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP       = vga_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_pkg::V_BP
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_en,
    vga_fb_if.master   fb,
    output logic [3:0] o_red,
    output logic [3:0] o_green,
    output logic [3:0] o_blue,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de,
    output logic       o_frame_start
);
    // Address register (1) + memory latency + output register (1)
    localparam int unsigned L   = 32'd2 + RD_LATENCY;
    localparam int unsigned DLY = L - 32'd1;

    typedef struct packed {
        logic de;
        logic hsync_n;
        logic vsync_n;
        logic fs;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, fs: 1'b0};

    logic             active_s, hsync_n_s, vsync_n_s, fstart_s, fend_s;
    logic [FB_AW-1:0] addr_cnt_q, addr_cnt_d;
    logic [FB_AW-1:0] raddr_q, raddr_d;
    ctl_t             raw_s;
    ctl_t             ctl_pipe_q [DLY];
    ctl_t             ctl_q, ctl_d;
    rgb444_t          rgb_q, rgb_d;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_en          (i_en),
        .o_active      (active_s),
        .o_hsync_n     (hsync_n_s),
        .o_vsync_n     (vsync_n_s),
        .o_frame_start (fstart_s),
        .o_frame_end   (fend_s)
    );

    // Linear pixel address: count visible positions, restart at end of frame
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        raddr_d    = raddr_q;
        if (!i_en) begin
            addr_cnt_d = '0;
        end else if (fend_s) begin
            addr_cnt_d = '0;
        end else if (active_s) begin
            raddr_d    = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + FB_AW'(1);
        end else begin
            addr_cnt_d = addr_cnt_q;
        end
    end

    // Address counter and registered read address
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_cnt_q <= '0;
            raddr_q    <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            raddr_q    <= raddr_d;
        end
    end

    assign fb.raddr = raddr_q;
    assign raw_s    = '{de: active_s, hsync_n: hsync_n_s, vsync_n: vsync_n_s, fs: fstart_s};

    // Control delay line, deep enough that its tail meets valid read data
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(DLY); i++) begin
                ctl_pipe_q[i] <= CTL_IDLE;
            end
        end else begin
            ctl_pipe_q[0] <= raw_s;
            for (int i = 1; i < int'(DLY); i++) begin
                ctl_pipe_q[i] <= ctl_pipe_q[i-1];
            end
        end
    end

    // Output stage inputs: pixel data only inside the visible area
    always_comb begin
        ctl_d = ctl_pipe_q[DLY-1];
        if (ctl_pipe_q[DLY-1].de) begin
            rgb_d = to_rgb(fb.rdata);
        end else begin
            rgb_d = RGB_BLACK;
        end
    end

    // Aligned output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctl_q <= CTL_IDLE;
            rgb_q <= RGB_BLACK;
        end else begin
            ctl_q <= ctl_d;
            rgb_q <= rgb_d;
        end
    end

    assign o_red         = rgb_q.r;
    assign o_green       = rgb_q.g;
    assign o_blue        = rgb_q.b;
    assign o_hsync       = ctl_q.hsync_n;
    assign o_vsync       = ctl_q.vsync_n;
    assign o_de          = ctl_q.de;
    assign o_frame_start = ctl_q.fs;
endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench: DUT A uses the full 640x480 timing with a 1-clock memory,
// DUT B a tiny raster (15x8) with a 2-clock memory so whole frames fit.
module tb_vga_display_ctrl;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en_a, en_b, force_fff;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [15:0] obs_a, obs_b;
    logic [11:0] rd_b1;

    vga_fb_if fb_a ();
    vga_fb_if fb_b ();

    vga_display_ctrl dut_a (
        .i_clk(clk), .i_rstn(rst_n), .i_en(en_a), .fb(fb_a),
        .o_red(r_a), .o_green(g_a), .o_blue(b_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a), .o_frame_start(fs_a)
    );

    vga_display_ctrl #(
        .RD_LATENCY(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .i_clk(clk), .i_rstn(rst_n), .i_en(en_b), .fb(fb_b),
        .o_red(r_b), .o_green(g_b), .o_blue(b_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b), .o_frame_start(fs_b)
    );

    assign obs_a = {fs_a, vs_a, hs_a, de_a, r_a, g_a, b_a};
    assign obs_b = {fs_b, vs_b, hs_b, de_b, r_b, g_b, b_b};

    // Frame-buffer contents: pixel 0 holds 0xF0A, others their address LSBs
    function automatic logic [11:0] mem_word(input logic [18:0] a, input logic ff);
        if (ff) return 12'hFFF;
        else if (a == 19'd0) return 12'hF0A;
        else return a[11:0];
    endfunction

    always @(posedge clk) fb_a.rdata <= mem_word(fb_a.raddr, 1'b0);
    always @(posedge clk) begin
        rd_b1      <= mem_word(fb_b.raddr, force_fff);
        fb_b.rdata <= rd_b1;
    end

    // Reference model state, index 0 = DUT A, 1 = DUT B
    int ha [2], hfp [2], hsw [2], va [2], vfp [2], vsw [2], ht [2], vt [2], lat [2];
    int pos [2];
    logic [18:0] exp_raddr [2];
    logic [15:0] pipe [2][4];   // {fs,vs,hs,de,rgb}, entry [lat-1] due now
    int n_cmp, n_fail;
    int wa_left, wa_hs, wa_de, wb_left, wb_vs, wb_hs, wb_de, wb_fs, wb_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected outputs for the cycle about to be clocked, from raster position
    task automatic model_cycle(input int d, input logic e, input logic ff);
        int h, v;
        logic act;
        logic [18:0] a;
        logic [15:0] w;
        w = 16'h6000;
        if (e) begin
            h = pos[d] % ht[d];
            v = (pos[d] / ht[d]) % vt[d];
            act = (h < ha[d]) && (v < va[d]);
            a = 19'(v * ha[d] + h);
            w[15] = (h == 0) && (v == 0);
            w[14] = !((v >= va[d] + vfp[d]) && (v < va[d] + vfp[d] + vsw[d]));
            w[13] = !((h >= ha[d] + hfp[d]) && (h < ha[d] + hfp[d] + hsw[d]));
            w[12] = act;
            if (act) begin
                w[11:0] = mem_word(a, ff);
                exp_raddr[d] = a;
            end
            pos[d] = (pos[d] + 1) % (ht[d] * vt[d]);
        end else begin
            pos[d] = 0;
        end
        for (int i = 3; i > 0; i--) pipe[d][i] = pipe[d][i-1];
        pipe[d][0] = w;
    endtask

    task automatic step();
        model_cycle(0, en_a, 1'b0);
        model_cycle(1, en_b, force_fff);
        @(posedge clk);
        #1;
        chk("A_out", 32'(obs_a), 32'(pipe[0][lat[0]-1]));
        chk("B_out", 32'(obs_b), 32'(pipe[1][lat[1]-1]));
        chk("A_raddr", 32'(fb_a.raddr), 32'(exp_raddr[0]));
        chk("B_raddr", 32'(fb_b.raddr), 32'(exp_raddr[1]));
        chk("A_bound", 32'(fb_a.raddr < 19'd307200), 32'd1);
        if (wa_left > 0) begin
            wa_hs += int'(!hs_a);
            wa_de += int'(de_a);
            wa_left--;
        end
        if (wb_left > 0) begin
            wb_vs += int'(!vs_b);
            wb_hs += int'(!hs_b);
            wb_de += int'(de_b);
            wb_fs += int'(fs_b);
            wb_bad += int'(!de_b && ({r_b, g_b, b_b} != 12'h000));
            wb_left--;
        end
    endtask

    initial begin
        ha = '{640, 8}; hfp = '{16, 2}; hsw = '{96, 3};
        va = '{480, 4}; vfp = '{10, 1}; vsw = '{2, 2};
        ht = '{800, 15}; vt = '{525, 8}; lat = '{3, 4};
        pos = '{0, 0};
        exp_raddr = '{19'd0, 19'd0};
        for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) pipe[d][i] = 16'h6000;
        n_cmp = 0; n_fail = 0;
        wa_left = 0; wa_hs = 0; wa_de = 0;
        wb_left = 0; wb_vs = 0; wb_hs = 0; wb_de = 0; wb_fs = 0; wb_bad = 0;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; force_fff = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("A_reset", 32'(obs_a), 32'h6000);
        chk("B_reset", 32'(obs_b), 32'h6000);
        chk("A_reset_raddr", 32'(fb_a.raddr), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // Enable: first pixel appears L clocks later with frame_start
        en_a = 1'b1; en_b = 1'b1;
        step(); step();
        chk("A_fs_early", 32'(fs_a), 32'd0);
        wa_left = 1600;
        step();
        chk("A_first_fs", 32'(fs_a), 32'd1);
        chk("A_first_rgb", 32'({r_a, g_a, b_a}), 32'hF0A);
        chk("A_first_de", 32'(de_a), 32'd1);
        chk("B_fs_early", 32'(fs_b), 32'd0);
        wb_left = 120;
        step();
        chk("B_first_fs", 32'(fs_b), 32'd1);
        chk("B_first_rgb", 32'({r_b, g_b, b_b}), 32'hF0A);

        // Run A up to raster position (320,2)
        for (int n = 0; n < 3000 && pos[0] != 1920; n++) step();
        chk("A_pos_reached", 32'(pos[0]), 32'd1920);
        chk("A_hs_2lines", 32'(wa_hs), 32'd192);
        chk("A_de_2lines", 32'(wa_de), 32'd1280);
        chk("B_vs_frame", 32'(wb_vs), 32'd30);
        chk("B_hs_frame", 32'(wb_hs), 32'd24);
        chk("B_de_frame", 32'(wb_de), 32'd32);
        chk("B_fs_frame", 32'(wb_fs), 32'd1);

        // Drop enable mid-line: reset-valued outputs within L clocks, address held
        en_a = 1'b0;
        repeat (3) step();
        chk("A_drop_out", 32'(obs_a), 32'h6000);
        chk("A_drop_raddr", 32'(fb_a.raddr), 32'd1599);
        repeat (47) step();
        en_a = 1'b1;
        step();
        chk("A_restart_raddr", 32'(fb_a.raddr), 32'd0);
        step(); step();
        chk("A_restart_fs", 32'(fs_a), 32'd1);
        chk("A_restart_rgb", 32'({r_a, g_a, b_a}), 32'hF0A);

        // Blanking with the frame buffer returning all ones
        en_b = 1'b0;
        repeat (6) step();
        force_fff = 1'b1;
        en_b = 1'b1;
        wb_de = 0; wb_bad = 0; wb_fs = 0;
        repeat (3) step();
        wb_left = 120;
        repeat (125) step();
        chk("B_blank_rgb", 32'(wb_bad), 32'd0);
        chk("B_fff_de", 32'(wb_de), 32'd32);
        chk("B_fff_fs", 32'(wb_fs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
